// File: rtl/da_lut_loader.sv
// Distributed-arithmetic LUT loader: collects 64 signed taps, then streams
// all 2048 partial-sum LUT entries (one per clock) to fir_filter.
module da_lut_loader #(
  parameter int COEF_W = 16
) (
  input  logic                     clk_slow,
  input  logic                     reset,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  output logic signed [COEF_W+2:0] CIN,
  output logic [10:0]              CADDR,
  output logic                     CLOAD,
  output logic                     load_done
);

  localparam int LUT_W = COEF_W + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COEF = 2'd1,
    GEN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [5:0]                r_tap;
  logic signed [COEF_W-1:0]  r_coef [0:63];
  logic                      w_hs;
  logic [10:0]               w_lut_addr;
  logic signed [LUT_W-1:0]   w_lut;

  // Handshake is only honoured while the loader is collecting taps
  assign w_hs = coef_valid & coef_ready & ((r_state == IDLE) | (r_state == COEF));

  // State register
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs) w_state_nxt = COEF;
        else      w_state_nxt = IDLE;
      end
      COEF: begin
        if (w_hs && (r_tap == 6'd63)) w_state_nxt = GEN;
        else                          w_state_nxt = COEF;
      end
      GEN: begin
        if (CADDR == 11'd2047) w_state_nxt = DONE;
        else                   w_state_nxt = GEN;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Coefficient store and tap index; r_tap wraps to 0 after tap 63
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      r_tap <= 6'd0;
      for (int i = 0; i < 64; i++) begin
        r_coef[i] <= {COEF_W{1'b0}};
      end
    end else if (w_hs) begin
      r_coef[r_tap] <= coef_in;
      r_tap         <= r_tap + 6'd1;
    end else begin
      r_tap <= r_tap;
    end
  end

  // Address of the entry presented next cycle: 0 on GEN entry, else CADDR+1
  always_comb begin
    w_lut_addr = 11'd0;
    if (r_state == GEN) begin
      w_lut_addr = CADDR + 11'd1;
    end else begin
      w_lut_addr = 11'd0;
    end
  end

  // Masked 8-input adder: sum of coef[8k+b] for each set bit b of a[7:0]
  always_comb begin
    w_lut = {LUT_W{1'b0}};
    for (int b = 0; b < 8; b++) begin
      if (w_lut_addr[b]) begin
        w_lut = w_lut + {{3{r_coef[{w_lut_addr[10:8], 3'(b)}][COEF_W-1]}},
                         r_coef[{w_lut_addr[10:8], 3'(b)}]};
      end else begin
        w_lut = w_lut;
      end
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      coef_ready <= 1'b0;
      CLOAD      <= 1'b0;
      CADDR      <= 11'd0;
      CIN        <= {LUT_W{1'b0}};
      load_done  <= 1'b0;
    end else begin
      coef_ready <= (w_state_nxt == IDLE) || (w_state_nxt == COEF);
      load_done  <= (w_state_nxt == DONE);
      if (w_state_nxt == GEN) begin
        CLOAD <= 1'b1;
        CADDR <= w_lut_addr;
        CIN   <= w_lut;
      end else begin
        CLOAD <= 1'b0;
        CADDR <= 11'd0;
        CIN   <= {LUT_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed self-checking bench for da_lut_loader (COEF_W = 16).
module tb_da_lut_loader;

  logic               clk_slow;
  logic               reset;
  logic signed [15:0] coef_in;
  logic               coef_valid;
  logic               coef_ready;
  logic signed [18:0] CIN;
  logic [10:0]        CADDR;
  logic               CLOAD;
  logic               load_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic signed [15:0] exp_taps [0:63];
  logic signed [18:0] cap_cin  [0:2047];
  logic [10:0]        cap_addr [0:2047];
  int n_load, done_cnt, first_idx, done_idx, ready_gen, n_hs;
  logic post_ready;

  da_lut_loader #(.COEF_W(16)) dut (
    .clk_slow  (clk_slow),
    .reset     (reset),
    .coef_in   (coef_in),
    .coef_valid(coef_valid),
    .coef_ready(coef_ready),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .load_done (load_done)
  );

  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  function automatic int lut_model(input int a);
    int s = 0;
    for (int b = 0; b < 8; b++) begin
      if (a[b]) s += int'(exp_taps[(a >> 8) * 8 + b]);
    end
    return s;
  endfunction

  // Drive taps 0..n-1 from exp_taps; counts handshakes actually taken
  task automatic load_taps(input bit toggle, input int n);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b0;
    while (i < n && cyc < 400) begin
      @(negedge clk_slow);
      cyc++;
      if (toggle && ph) begin
        coef_valid = 1'b0;
        coef_in    = 16'sh5A5A;
      end else begin
        coef_valid = 1'b1;
        coef_in    = exp_taps[i];
      end
      ph = ~ph;
      if (coef_valid && coef_ready) i++;
    end
    n_hs = i;
  endtask

  // Record one GEN burst starting at the first negedge after the last handshake
  task automatic capture(input bit garbage);
    n_load = 0; done_cnt = 0; first_idx = -1; done_idx = -1; ready_gen = 0;
    post_ready = 1'b0;
    for (int c = 0; c < 2100; c++) begin
      @(negedge clk_slow);
      if (CLOAD) begin
        if (first_idx < 0) first_idx = c;
        if (n_load < 2048) begin
          cap_cin[n_load]  = CIN;
          cap_addr[n_load] = CADDR;
        end
        n_load++;
        if (coef_ready) ready_gen++;
      end
      if (load_done) begin
        done_cnt++;
        done_idx = c;
      end
      if (done_cnt > 0 && c == done_idx + 1) post_ready = coef_ready;
      coef_valid = garbage && (done_cnt == 0);
      coef_in    = garbage ? 16'($urandom) : 16'sd0;
      if (done_cnt > 0 && c >= done_idx + 1) break;
    end
  endtask

  task automatic check_burst(input string tag);
    int gaps = 0;
    int mism = 0;
    tests_run++;
    if (n_hs !== 64) begin
      tests_failed++; $display("FAIL %s handshakes: got %0d expected 64", tag, n_hs);
    end
    tests_run++;
    if (first_idx !== 0) begin
      tests_failed++; $display("FAIL %s first_cload: got cycle %0d expected 0", tag, first_idx);
    end
    tests_run++;
    if (n_load !== 2048) begin
      tests_failed++; $display("FAIL %s cload_cycles: got %0d expected 2048", tag, n_load);
    end
    for (int a = 0; a < 2048; a++) begin
      if (cap_addr[a] !== 11'(a)) gaps++;
      if (int'(cap_cin[a]) !== lut_model(a)) mism++;
    end
    tests_run++;
    if (gaps !== 0) begin
      tests_failed++; $display("FAIL %s caddr_seq: got %0d bad addresses expected 0", tag, gaps);
    end
    tests_run++;
    if (mism !== 0) begin
      tests_failed++; $display("FAIL %s lut_values: got %0d wrong entries expected 0", tag, mism);
    end
    tests_run++;
    if (done_cnt !== 1 || done_idx !== 2048) begin
      tests_failed++;
      $display("FAIL %s load_done: got %0d pulses at %0d expected 1 at 2048", tag, done_cnt, done_idx);
    end
    tests_run++;
    if (ready_gen !== 0 || post_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s coef_ready: got %0d in GEN, %0b after expected 0, 1", tag, ready_gen, post_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; coef_valid = 1'b0; coef_in = 16'sd0;
    repeat (3) @(negedge clk_slow);
    tests_run++;
    if ({coef_ready, CLOAD, CADDR, CIN, load_done} !== 33'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%0b cload=%0b caddr=%0d cin=%0d done=%0b expected all 0",
               coef_ready, CLOAD, CADDR, CIN, load_done);
    end
    reset = 1'b0;
    @(negedge clk_slow);
    tests_run++;
    if (coef_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready_rise: got %0b expected 1", coef_ready);
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 64; i++) exp_taps[i] = 16'sd1;
    load_taps(1'b0, 64);
    capture(1'b0);
    check_burst("ones");
    tests_run++;
    if (cap_cin[0] !== 19'sd0 || cap_cin[1] !== 19'sd1 || cap_cin[255] !== 19'sd8 || cap_cin[1962] !== 19'sd4) begin
      tests_failed++;
      $display("FAIL ones_points: got %0d %0d %0d %0d expected 0 1 8 4",
               cap_cin[0], cap_cin[1], cap_cin[255], cap_cin[1962]);
    end
  endtask

  task automatic test_all_min();
    for (int i = 0; i < 64; i++) exp_taps[i] = -16'sd32768;
    load_taps(1'b0, 64);
    capture(1'b0);
    check_burst("min");
    tests_run++;
    if (int'(cap_cin[255]) !== -262144 || int'(cap_cin[769]) !== -32768) begin
      tests_failed++;
      $display("FAIL min_points: got %0d %0d expected -262144 -32768", cap_cin[255], cap_cin[769]);
    end
  endtask

  task automatic test_toggle_ramp();
    for (int i = 0; i < 64; i++) exp_taps[i] = 16'(i);
    load_taps(1'b1, 64);
    capture(1'b0);
    check_burst("ramp");
    tests_run++;
    if (int'(cap_cin[511]) !== 92 || int'(cap_cin[1920]) !== 63) begin
      tests_failed++;
      $display("FAIL ramp_points: got %0d %0d expected 92 63", cap_cin[511], cap_cin[1920]);
    end
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    for (int i = 0; i < 64; i++) exp_taps[i] = 16'(i + 100);
    load_taps(1'b0, 10);
    @(negedge clk_slow);
    coef_valid = 1'b0; reset = 1'b1;
    @(negedge clk_slow);
    reset = 1'b0;
    @(negedge clk_slow);
    load_taps(1'b0, 64);
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk_slow);
      coef_valid = 1'b0;
      if (CLOAD && CADDR == 11'd1000) begin
        hit = 1'b1;
        reset = 1'b1;
        break;
      end
    end
    tests_run++;
    if (hit !== 1'b1) begin
      tests_failed++; $display("FAIL abort_reach_1000: got %0b expected 1", hit);
    end
    @(negedge clk_slow);
    tests_run++;
    if ({CLOAD, CADDR, CIN, load_done, coef_ready} !== 33'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got cload=%0b caddr=%0d cin=%0d expected 0 0 0", CLOAD, CADDR, CIN);
    end
    reset = 1'b0;
    for (int i = 0; i < 64; i++) exp_taps[i] = 16'(3 * i - 90);
    load_taps(1'b0, 64);
    capture(1'b0);
    check_burst("reload");
    tests_run++;
    if (int'(cap_cin[1]) !== -90 || int'(cap_cin[255]) !== -636) begin
      tests_failed++;
      $display("FAIL reload_points: got %0d %0d expected -90 -636", cap_cin[1], cap_cin[255]);
    end
  endtask

  task automatic test_garbage_gen();
    for (int i = 0; i < 64; i++) exp_taps[i] = (i % 2 == 1) ? 16'(-3 * i) : 16'(7 * i);
    load_taps(1'b0, 64);
    capture(1'b1);
    check_burst("garbage");
    tests_run++;
    if (int'(cap_cin[3]) !== -3 || int'(cap_cin[515]) !== 61) begin
      tests_failed++;
      $display("FAIL garbage_points: got %0d %0d expected -3 61", cap_cin[3], cap_cin[515]);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_min();
    test_toggle_ramp();
    test_abort();
    test_garbage_gen();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
